i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_rr_pick.sv | 10 +
 rtl/i2c_arbiter.sv | 115 +++++++++++
 tb/tb_i2c_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and error codes shared by the I2C arbiter slice.
package i2c_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [3:0] E_TIMEOUT   = 4'hF;
  localparam logic [3:0] E_ACK_DEV   = 4'h1;
  localparam logic [3:0] E_ACK_REG   = 4'h2;
  localparam logic [3:0] E_ACK_WR    = 4'h4;
  localparam logic [3:0] E_ACK_RD    = 4'h8;
endpackage

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: two-way round-robin selector; on a tie the port not granted last wins.
module i2c_rr_pick (
  input  logic [1:0] pending,
  input  logic       last,
  output logic       sel,
  output logic       valid
);
  assign valid = |pending;
  assign sel = &pending ? ~last : pending[1];
endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between two request ports, with ACK-error retry and a busy timeout.
module i2c_arbiter import i2c_pkg::*; #(
  parameter int unsigned P_RETRY   = 2,
  parameter logic [15:0] P_TIMEOUT = 16'd255
) (
  input  logic        i_local_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_dev_addr,
  input  logic [15:0] i_reg_addr,
  input  logic [15:0] i_req_num,
  input  logic [15:0] i_wr_data,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_wr_next,
  output logic [7:0]  o_rd_data,
  output logic [1:0]  o_rd_valid,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic [3:0]  o_err_code,
  output logic        o_start,
  output logic [7:0]  o_device_addr,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_req_num,
  output logic [7:0]  o_wr_data,
  input  logic        i_busy,
  input  logic        i_wr_done,
  input  logic [7:0]  i_rd_data,
  input  logic        i_rd_valid,
  input  logic [7:0]  i_ack_erro,
  input  logic        i_erro_valid
);
  localparam logic [7:0] RETRY_MAX = 8'(P_RETRY);
  logic [2:0]  state;
  logic [1:0]  pending, own_oh, pick_oh;
  logic        last, owner, pick_sel, pick_valid, err, run;
  logic [3:0]  err_code;
  logic [7:0]  retry;
  logic [15:0] tcnt;
  logic        unused;
  i2c_rr_pick u_pick (.pending(pending), .last(last), .sel(pick_sel), .valid(pick_valid));
  assign unused = ^i_ack_erro[7:4];
  assign run = state == S_RUN;
  assign own_oh = owner ? 2'b10 : 2'b01;
  assign pick_oh = (state == S_IDLE && pick_valid) ? (pick_sel ? 2'b10 : 2'b01) : 2'b00;
  assign o_gnt = (state != S_IDLE) ? own_oh : 2'b00;
  assign o_start = state == S_ISSUE;
  assign o_done = (state == S_DONE) ? own_oh : 2'b00;
  assign o_err = (state == S_DONE && err) ? own_oh : 2'b00;
  assign o_err_code = (state == S_DONE) ? err_code : 4'h0;
  assign o_wr_data = o_gnt[0] ? i_wr_data[7:0] : o_gnt[1] ? i_wr_data[15:8] : 8'h00;
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      pending       <= '0;
      last          <= 1'b1;
      owner         <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
      retry         <= '0;
      tcnt          <= '0;
      o_device_addr <= '0;
      o_reg_addr    <= '0;
      o_req_num     <= '0;
      o_wr_next     <= '0;
      o_rd_valid    <= '0;
      o_rd_data     <= '0;
    end else begin
      // requests from the current owner are dropped, not queued
      pending    <= (pending | (i_req & ~o_gnt)) & ~pick_oh;
      o_wr_next  <= (run && i_wr_done) ? own_oh : 2'b00;
      o_rd_valid <= (run && i_rd_valid) ? own_oh : 2'b00;
      if (run && i_rd_valid) o_rd_data <= i_rd_data;
      case (state)
        S_IDLE: if (pick_valid) begin
          owner         <= pick_sel;
          o_device_addr <= pick_sel ? i_dev_addr[15:8] : i_dev_addr[7:0];
          o_reg_addr    <= pick_sel ? i_reg_addr[15:8] : i_reg_addr[7:0];
          o_req_num     <= pick_sel ? i_req_num[15:8] : i_req_num[7:0];
          retry         <= '0;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          err      <= 1'b0;
          err_code <= '0;
          tcnt     <= '0;
          state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY:
          if (i_busy) state <= S_RUN;
          else if (tcnt == P_TIMEOUT - 16'd1) begin
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
            state    <= S_DONE;
          end else tcnt <= tcnt + 16'd1;
        S_RUN: begin
          if (i_erro_valid) begin
            err      <= 1'b1;
            err_code <= i_ack_erro[3:0];
          end
          if (!i_busy) state <= S_CHECK;
        end
        S_CHECK:
          if (err && retry < RETRY_MAX) begin
            retry <= retry + 8'd1;
            state <= S_ISSUE;
          end else state <= S_DONE;
        S_DONE: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed bench for the two-port I2C arbiter with hand-computed expectations.
module tb_i2c_arbiter;
  logic        clk, rst_n;
  logic [1:0]  req;
  logic [15:0] dev, rega, num, wd;
  logic [1:0]  o_gnt, o_wr_next, o_rd_valid, o_done, o_err;
  logic [7:0]  o_rd_data, o_device_addr, o_reg_addr, o_req_num, o_wr_data;
  logic [3:0]  o_err_code;
  logic        o_start;
  logic        busy, wr_done, rd_valid, erro_valid;
  logic [7:0]  rd_data, ack;
  int total = 0, bad = 0;
  int start_cnt = 0, done_cnt = 0, gnt_both = 0;

  i2c_arbiter dut (
    .i_local_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_dev_addr(dev), .i_reg_addr(rega), .i_req_num(num), .i_wr_data(wd),
    .o_gnt(o_gnt), .o_wr_next(o_wr_next), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_start(o_start), .o_device_addr(o_device_addr), .o_reg_addr(o_reg_addr),
    .o_req_num(o_req_num), .o_wr_data(o_wr_data),
    .i_busy(busy), .i_wr_done(wr_done), .i_rd_data(rd_data), .i_rd_valid(rd_valid),
    .i_ack_erro(ack), .i_erro_valid(erro_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_start === 1'b1) start_cnt++;
    if (o_done !== 2'b00) done_cnt++;
    if (o_gnt === 2'b11) gnt_both++;
  endtask

  initial begin
    logic [7:0] rb [3];
    int cyc, n;
    rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33;
    rst_n = 1'b0; req = '0; dev = '0; rega = '0; num = '0; wd = '0;
    busy = 1'b0; wr_done = 1'b0; rd_valid = 1'b0; rd_data = '0; ack = '0; erro_valid = 1'b0;
    #1;
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_start", 32'(o_start), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_wdata", 32'(o_wr_data), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // port0 write, two bytes, all ACKed
    dev = 16'h00A0; rega = 16'h0010; num = 16'h0002; wd = 16'hC35A;
    req = 2'b01; tick(); req = 2'b00;
    chk("t1_n1_gnt", 32'(o_gnt), 32'h0);
    chk("t1_n1_start", 32'(o_start), 32'h0);
    tick();
    chk("t1_n2_gnt", 32'(o_gnt), 32'h1);
    chk("t1_n2_start", 32'(o_start), 32'h1);
    chk("t1_dev", 32'(o_device_addr), 32'hA0);
    chk("t1_reg", 32'(o_reg_addr), 32'h10);
    chk("t1_num", 32'(o_req_num), 32'h2);
    chk("t1_wdata", 32'(o_wr_data), 32'h5A);
    tick();
    chk("t1_start_once", 32'(o_start), 32'h0);
    busy = 1'b1;
    tick();
    wr_done = 1'b1; req = 2'b01;
    tick();
    wr_done = 1'b0; req = 2'b00;
    chk("t1_wrnext_a", 32'(o_wr_next), 32'h1);
    tick();
    chk("t1_wrnext_gap", 32'(o_wr_next), 32'h0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("t1_wrnext_b", 32'(o_wr_next), 32'h1);
    tick();
    busy = 1'b0;
    tick(); tick();
    chk("t1_done", 32'(o_done), 32'h1);
    chk("t1_err", 32'(o_err), 32'h0);
    chk("t1_gnt_in_done", 32'(o_gnt), 32'h1);
    tick();
    chk("t1_idle_gnt", 32'(o_gnt), 32'h0);
    tick();
    chk("t1_req_ignored", 32'(o_gnt), 32'h0);

    // port1 read of three bytes
    dev = 16'h5100; rega = 16'h2000; num = 16'h0300; wd = 16'hC35A;
    req = 2'b10; tick(); req = 2'b00; tick();
    chk("t5_gnt", 32'(o_gnt), 32'h2);
    chk("t5_start", 32'(o_start), 32'h1);
    chk("t5_dev", 32'(o_device_addr), 32'h51);
    chk("t5_num", 32'(o_req_num), 32'h3);
    chk("t5_wdata", 32'(o_wr_data), 32'hC3);
    tick();
    busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rd_data = rb[i]; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      chk("t5_rdv", 32'(o_rd_valid), 32'h2);
      chk("t5_rdd", 32'(o_rd_data), 32'(rb[i]));
      tick();
      chk("t5_rdv_gap", 32'(o_rd_valid), 32'h0);
    end
    busy = 1'b0;
    tick(); tick();
    chk("t5_done", 32'(o_done), 32'h2);
    chk("t5_err", 32'(o_err), 32'h0);
    tick();

    // simultaneous requests after port1 was served last: port0 first
    dev = 16'h5BA2; gnt_both = 0;
    req = 2'b11; tick(); req = 2'b00; tick();
    chk("t2_first_gnt", 32'(o_gnt), 32'h1);
    chk("t2_first_dev", 32'(o_device_addr), 32'hA2);
    tick(); busy = 1'b1;
    tick(); busy = 1'b0;
    tick(); tick();
    chk("t2_first_done", 32'(o_done), 32'h1);
    tick();
    chk("t2_gap_gnt", 32'(o_gnt), 32'h0);
    tick();
    chk("t2_second_gnt", 32'(o_gnt), 32'h2);
    chk("t2_second_start", 32'(o_start), 32'h1);
    chk("t2_second_dev", 32'(o_device_addr), 32'h5B);
    tick(); busy = 1'b1;
    tick(); busy = 1'b0;
    tick(); tick();
    chk("t2_second_done", 32'(o_done), 32'h2);
    tick();
    chk("t2_never_both", 32'(gnt_both), 32'h0);

    // master never raises busy: timeout
    dev = 16'h00A4;
    req = 2'b01; tick(); req = 2'b00; tick();
    chk("t3_start", 32'(o_start), 32'h1);
    cyc = 0;
    while (o_done === 2'b00 && cyc < 1000) begin tick(); cyc++; end
    chk("t3_cycles", 32'(cyc), 32'd256);
    chk("t3_done", 32'(o_done), 32'h1);
    chk("t3_err", 32'(o_err), 32'h1);
    chk("t3_code", 32'(o_err_code), 32'hF);
    tick();

    // device NACK on every attempt, error and busy-fall in the same cycle
    start_cnt = 0;
    req = 2'b01; tick(); req = 2'b00;
    for (int a = 0; a < 3; a++) begin
      n = 0;
      while (o_start !== 1'b1 && n < 20) begin tick(); n++; end
      chk("t4_start_seen", 32'(o_start), 32'h1);
      tick(); busy = 1'b1;
      tick(); busy = 1'b0; erro_valid = 1'b1; ack = 8'h01;
      tick(); erro_valid = 1'b0; ack = 8'h00;
    end
    tick();
    chk("t4_done", 32'(o_done), 32'h1);
    chk("t4_err", 32'(o_err), 32'h1);
    chk("t4_code", 32'(o_err_code), 32'h1);
    tick(); tick(); tick();
    chk("t4_start_count", 32'(start_cnt), 32'd3);

    // reset in the middle of a port1 transaction
    dev = 16'h5BA6;
    req = 2'b10; tick(); req = 2'b00; tick();
    chk("t6_gnt_before", 32'(o_gnt), 32'h2);
    tick(); busy = 1'b1;
    tick();
    done_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(o_gnt), 32'h0);
    chk("t6_rst_dev", 32'(o_device_addr), 32'h0);
    chk("t6_rst_wdata", 32'(o_wr_data), 32'h0);
    busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_done", 32'(done_cnt), 32'h0);
    chk("t6_idle_gnt", 32'(o_gnt), 32'h0);
    req = 2'b11; tick(); req = 2'b00; tick();
    chk("t6_port0_first", 32'(o_gnt), 32'h1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
